// File: rtl/arith_pkg.sv
// arith_pkg: shared types and helpers for the sequential digit adder.
//   state_t  - controller states (IDLE, RUN, DONE)
//   ndig_of  - number of digits an operand is split into
//   cnt_w    - digit counter width, never less than one bit
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ndig_of(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_w(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// digit_adder: combinational ripple of DIGIT one-bit full-adder cells.
//   x, y     - DIGIT-bit addends
//   ci       - carry into bit 0
//   s        - DIGIT-bit sum
//   co       - carry out of the top bit
//   c_msb_in - carry into the top bit (signed-overflow detection)
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co       = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/seq_digit_adder.sv
// seq_digit_adder: multi-cycle adder/subtractor processing DIGIT bits per
// clock with a registered carry chained between digits.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid, in_ready   - operand handshake (a, b, cin, sub)
//   a, b                 - WIDTH-bit operands
//   cin                  - carry-in for add; ignored for subtract
//   sub                  - 0: a+b+cin, 1: a-b
//   out_valid, out_ready - result handshake
//   sum                  - WIDTH-bit result, modulo 2^WIDTH
//   cout                 - carry out of the MSB (subtract: 1 = no borrow)
//   ovf                  - two's-complement signed overflow
module seq_digit_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = ndig_of(WIDTH, DIGIT);
  localparam int CW   = cnt_w(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("seq_digit_adder: DIGIT must be >= 1 and divide WIDTH exactly");
  end

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q;

  logic             accept, last_dig;
  logic [DIGIT-1:0] x_dig, y_dig, s_dig;
  logic             co_dig, cmsb_dig;

  assign accept   = in_valid && in_ready;
  assign last_dig = (cnt_q == LAST);

  // One shared digit adder, its operands selected by the digit counter.
  assign x_dig = a_q[cnt_q*DIGIT +: DIGIT];
  assign y_dig = b_q[cnt_q*DIGIT +: DIGIT];

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x        (x_dig),
    .y        (y_dig),
    .ci       (carry_q),
    .s        (s_dig),
    .co       (co_dig),
    .c_msb_in (cmsb_dig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)    state_nx = RUN;
      RUN:     if (last_dig)  state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    in_ready  = 1'b1;
      RUN:     ;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Subtraction is a + ~b + 1: invert B once at load and seed the carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          sum_q[cnt_q*DIGIT +: DIGIT] <= s_dig;
          carry_q <= co_dig;
          cnt_q   <= cnt_q + 1'b1;
          if (last_dig) begin
            cout_q <= co_dig;
            ovf_q  <= cmsb_dig ^ co_dig;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/seq_digit_adder.md
Name: seq_digit_adder

Overview:
Parametrised multi-cycle adder/subtractor. Adds two WIDTH-bit operands DIGIT bits per clock, using a registered carry chained between digits. Operands enter and results leave through valid/ready handshakes. It is the sequential, width-generic successor to the single-bit combinational full adder, for arithmetic datapaths where area matters more than latency.

Parameters:
WIDTH, 8, operand and sum width in bits; must be at least 1.
DIGIT, 2, bits processed per clock; must divide WIDTH exactly (elaboration-time assertion).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and mode are valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in; ignored when sub=1
sub  input  1  0 = A+B+cin, 1 = A-B
out_valid  output  1  result is valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  result
cout  output  1  carry-out from the MSB; for subtract, 1 means no borrow (A >= B unsigned)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0. Digit counter and carry register reset to 0.
- NDIG = WIDTH/DIGIT. Digit counter width is clog2(NDIG), minimum 1.
- State machine, three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Operands are accepted when in_valid && in_ready.
  - On acceptance: A register <= a; B register <= sub ? ~b : b; carry <= sub ? 1 : cin; counter <= 0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, digit k = counter is added: the A and B bits [k*DIGIT +: DIGIT] plus carry.
  - The DIGIT-bit result is written into sum[k*DIGIT +: DIGIT]. Digit carry-out goes to the carry register. Counter increments.
  - On digit NDIG-1:
    - cout <= carry out of bit WIDTH-1.
    - ovf <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
    - Go to DONE.
- DONE:
  - out_valid=1. sum, cout and ovf are held stable.
  - When out_ready=1, go to IDLE and drop out_valid the next cycle.
  - No new operand is accepted in DONE (in_ready=0).
- Latency: out_valid rises NDIG clocks after the acceptance edge. With DIGIT=WIDTH this is 1 clock.
- Throughput: one operation per NDIG+2 cycles when out_ready is held high.
- sum is undefined while out_valid=0 after the first operation. It is updated only during RUN and is only guaranteed in DONE.
- in_valid asserted while in_ready=0 is ignored; no queuing. The source must hold its operands until accepted.
- a, b, cin and sub are sampled only on the acceptance edge. Later input changes have no effect on the operation in flight.
- Wrap-around: the sum is modulo 2^WIDTH. Carry-out is reported only through cout.
- Reset mid-operation (RUN or DONE): everything returns to reset values immediately. The in-flight result is discarded and no out_valid pulse is produced.
- Back-pressure: out_ready low holds DONE indefinitely with stable outputs.

Decomposition:
- Shared package arith_pkg:
  - state enum typedef (IDLE, RUN, DONE);
  - a function for the counter width;
  - the NDIG derivation.
- One sub-module, digit_adder (parameter DIGIT):
  - combinational ripple of DIGIT one-bit full-adder cells;
  - inputs: x, y, ci; outputs: s, co, and c_msb_in (carry into the top bit, used for ovf);
  - instantiated once and muxed by the counter.

Test Plan:
- WIDTH=8, DIGIT=2, sub=0, a=8'hFF, b=8'h01, cin=0 -> out_valid exactly 4 clocks after acceptance; sum=8'h00, cout=1, ovf=0.
- sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, cout=0, ovf=0. Repeat with a=8'h07, b=8'h05 -> sum=8'h02, cout=1.
- sub=0, a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, ovf=1, cout=0. sub=0, a=8'h80, b=8'h80 -> sum=8'h00, ovf=1, cout=1.
- Back-pressure: hold out_ready=0 for 3 cycles after out_valid -> sum, cout and ovf stable. in_valid pulsed during RUN and DONE is ignored (in_ready=0). The next op is accepted only after returning to IDLE.
- Reset mid-RUN: deassert rst_n asynchronously on RUN digit 2 -> outputs go to 0 immediately, in_ready=1 after release, and no out_valid appears for the aborted op.
- Parameter sweep: DIGIT in {1, WIDTH}, WIDTH in {4, 16}, 1000 random ops -> sum, cout and ovf match a golden model; latency equals WIDTH/DIGIT.
